// File: rtl/conv3x3_sched_if.sv
// Handshake bundle between conv3x3_sched, the window/weight source,
// the conv core and the result consumer.
// master = scheduler side, slave = environment side.
//   fetch_*   : window/weight request stream (fetch_vld / fetch_ready)
//   conv_in_* : valid + channel config towards the core
//   conv_out_*: core result (fixed latency, no stall)
//   res_*     : result stream (res_vld / res_ready, res_last on final)
interface conv3x3_sched_if #(
    parameter int DIMW = 8
);
    logic            fetch_vld;
    logic            fetch_ready;
    logic [DIMW-1:0] fetch_x;
    logic [DIMW-1:0] fetch_y;
    logic [DIMW-1:0] fetch_oc;
    logic            conv_in_vld;
    logic [3:0]      conv_in_ch_cfg;
    logic            conv_out_vld;
    logic [31:0]     conv_out_sum;
    logic            res_vld;
    logic            res_ready;
    logic [31:0]     res_data;
    logic            res_last;

    modport master (
        output fetch_vld, fetch_x, fetch_y, fetch_oc,
        output conv_in_vld, conv_in_ch_cfg,
        output res_vld, res_data, res_last,
        input  fetch_ready, conv_out_vld, conv_out_sum, res_ready
    );

    modport slave (
        input  fetch_vld, fetch_x, fetch_y, fetch_oc,
        input  conv_in_vld, conv_in_ch_cfg,
        input  res_vld, res_data, res_last,
        output fetch_ready, conv_out_vld, conv_out_sum, res_ready
    );
endinterface

// File: rtl/conv3x3_sched.sv
// Sequencer for the 3x3 conv-sum core: walks x/y/oc, issues fetches,
// tracks core latency and buffers results in a credit-protected FIFO.
// Ports: clk, rst_b (async low), start/cfg_* (layer config), busy, done,
// bus (conv3x3_sched_if.master: fetch, core in/out, result stream).
// Option: define OUT_SAT16_EN to saturate results to 65535 at push.
module conv3x3_sched #(
    parameter int CORE_LAT   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int DIMW       = 8
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [DIMW-1:0] cfg_ofm_w,
    input  logic [DIMW-1:0] cfg_ofm_h,
    input  logic [DIMW-1:0] cfg_oc,
    input  logic [3:0]      cfg_ic,
    output logic            busy,
    output logic            done,
    conv3x3_sched_if.master bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int IFW = $clog2(CORE_LAT + 1);
    localparam int TW  = 3 * DIMW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]          state_q;
    logic [DIMW-1:0]     w_q, h_q, oc_q;
    logic [3:0]          ic_q;
    logic [DIMW-1:0]     x_q, y_q, oc_cnt_q;
    logic [TW-1:0]       total_q, pop_cnt_q;
    logic [CORE_LAT-1:0] sr_q;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q;

    logic [IFW-1:0] in_flight;
    logic [15:0]    occ;
    logic           res_vld, pop, full, push, push_ok;
    logic           fetch_vld, hs;
    logic           x_last, y_last, oc_last, last_fetch;
    logic           zero_cfg, drained;
    logic [31:0]    push_data;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < CORE_LAT; i++) begin
            in_flight = in_flight + IFW'(sr_q[i]);
        end
    end

    assign res_vld = (cnt_q != '0);
    assign pop     = res_vld & bus.res_ready;
    assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign push    = bus.conv_out_vld;
    assign push_ok = push & (~full | pop);

    // Reserved slots = results in the core + results in the FIFO.
    // An entry leaving this cycle frees its slot, so back-to-back
    // fetches continue while the consumer keeps up.
    assign occ = 16'(in_flight) + 16'(cnt_q) - 16'(pop);
    assign fetch_vld = (state_q == ST_RUN) && (occ < 16'(FIFO_DEPTH));
    assign hs = fetch_vld & bus.fetch_ready;

    assign x_last     = (x_q == w_q - DIMW'(1));
    assign y_last     = (y_q == h_q - DIMW'(1));
    assign oc_last    = (oc_cnt_q == oc_q - DIMW'(1));
    assign last_fetch = x_last & y_last & oc_last;

    assign zero_cfg = (cfg_ofm_w == '0) || (cfg_ofm_h == '0) ||
                      (cfg_oc == '0);

    // Leave DRAIN in the same cycle the last entry is popped so that
    // done lands on the following cycle.
    assign drained = (in_flight == '0) &&
                     ((cnt_q == '0) ||
                      ((cnt_q == (AW+1)'(1)) && pop));

`ifdef OUT_SAT16_EN
    assign push_data = (bus.conv_out_sum > 32'd65535) ?
                       32'd65535 : bus.conv_out_sum;
`else
    assign push_data = bus.conv_out_sum;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            w_q       <= '0;
            h_q       <= '0;
            oc_q      <= '0;
            ic_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            oc_cnt_q  <= '0;
            total_q   <= '0;
            pop_cnt_q <= '0;
        end else begin
            if (pop) begin
                pop_cnt_q <= pop_cnt_q + TW'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        w_q       <= cfg_ofm_w;
                        h_q       <= cfg_ofm_h;
                        oc_q      <= cfg_oc;
                        ic_q      <= cfg_ic;
                        x_q       <= '0;
                        y_q       <= '0;
                        oc_cnt_q  <= '0;
                        pop_cnt_q <= '0;
                        total_q   <= TW'(cfg_ofm_w) * TW'(cfg_ofm_h) *
                                     TW'(cfg_oc);
                        state_q   <= zero_cfg ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        if (!x_last) begin
                            x_q <= x_q + DIMW'(1);
                        end else begin
                            x_q <= '0;
                            if (!y_last) begin
                                y_q <= y_q + DIMW'(1);
                            end else begin
                                y_q      <= '0;
                                oc_cnt_q <= oc_last ? '0 :
                                            oc_cnt_q + DIMW'(1);
                            end
                        end
                        if (last_fetch) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sr_q <= '0;
        end else begin
            sr_q <= (sr_q << 1) | CORE_LAT'(hs);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (!push_ok && pop) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_b) !(push && full && !pop)
    );

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

    assign bus.fetch_vld      = fetch_vld;
    assign bus.fetch_x        = x_q;
    assign bus.fetch_y        = y_q;
    assign bus.fetch_oc       = oc_cnt_q;
    assign bus.conv_in_vld    = hs;
    assign bus.conv_in_ch_cfg = ic_q;
    assign bus.res_vld        = res_vld;
    assign bus.res_data       = mem_q[rd_ptr_q];
    assign bus.res_last       = res_vld && (pop_cnt_q == total_q - TW'(1));
endmodule

// File: tb/tb_conv3x3_sched.sv
// Scoreboard bench for conv3x3_sched: random layers, a fixed-latency
// core model, and directed backpressure/stall/zero/reset/sat cases.
module tb_conv3x3_sched;
    localparam int DIMW = 8;
    localparam int LAT  = 3;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            start;
    logic [DIMW-1:0] cfg_ofm_w, cfg_ofm_h, cfg_oc;
    logic [3:0]      cfg_ic;
    logic            busy, done;

    conv3x3_sched_if #(.DIMW(DIMW)) bus ();

    conv3x3_sched #(
        .CORE_LAT(LAT), .FIFO_DEPTH(4), .DIMW(DIMW)
    ) dut (
        .clk(clk), .rst_b(rst_b), .start(start),
        .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_h(cfg_ofm_h),
        .cfg_oc(cfg_oc), .cfg_ic(cfg_ic),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] vals[256];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lw = 1, lh = 1, loc = 1, ltot = 0;
    logic [3:0] lic = 4'd0;
    int fr_mode = 0, rr_mode = 0;
    bit chk_consec = 0;

    // monitor-owned state
    int fetch_idx = 0, hs_count = 0, n_pops = 0;
    int hs_prev = 0, exp_done_cyc = -1;
    bit held_f = 0, held_r = 0;
    logic [DIMW-1:0] hx, hy, hoc;
    logic [31:0] hd;
    logic hl;
    logic [LAT-1:0] p_v;
    logic [31:0] p_d[LAT];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_out(input logic [31:0] v);
`ifdef OUT_SAT16_EN
        return (v > 32'd65535) ? 32'd65535 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (fr_mode)
            0: bus.fetch_ready = 1'b1;
            1: bus.fetch_ready = ($urandom_range(0, 3) != 0);
            2: bus.fetch_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: bus.fetch_ready = 1'b0;
        endcase
        case (rr_mode)
            0: bus.res_ready = 1'b1;
            1: bus.res_ready = ($urandom_range(0, 1) != 0);
            default: bus.res_ready = 1'b0;
        endcase
    end

    // Core model + monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_b) begin
            p_v = '0;
            bus.conv_out_vld = 1'b0;
            bus.conv_out_sum = '0;
            fetch_idx = 0;
            hs_count = 0;
            n_pops = 0;
            held_f = 0;
            held_r = 0;
        end else begin
            bus.conv_out_vld = p_v[LAT-1];
            bus.conv_out_sum = p_d[LAT-1];
            for (int i = LAT - 1; i > 0; i--) begin
                p_v[i] = p_v[i-1];
                p_d[i] = p_d[i-1];
            end
            p_v[0] = 1'b0;

            if (start && !busy) begin
                fetch_idx = 0;
                hs_count = 0;
                n_pops = 0;
                exp_done_cyc = cyc + 1;
            end

            if (bus.conv_in_vld || bus.fetch_vld)
                check("conv_in_vld", bus.conv_in_vld,
                      bus.fetch_vld & bus.fetch_ready);

            if (held_f && bus.fetch_vld) begin
                check("hold_x", bus.fetch_x, hx);
                check("hold_y", bus.fetch_y, hy);
                check("hold_oc", bus.fetch_oc, hoc);
            end

            if (bus.fetch_vld && bus.fetch_ready) begin
                if (fetch_idx >= ltot) begin
                    check("extra_fetch", fetch_idx, ltot - 1);
                end else begin
                    check("fetch_x", bus.fetch_x, fetch_idx % lw);
                    check("fetch_y", bus.fetch_y, (fetch_idx / lw) % lh);
                    check("fetch_oc", bus.fetch_oc, fetch_idx / (lw * lh));
                end
                check("ch_cfg", bus.conv_in_ch_cfg, lic);
                if (chk_consec && fetch_idx > 0)
                    check("fetch_gap", cyc - hs_prev, 1);
                hs_prev = cyc;
                p_v[0] = 1'b1;
                p_d[0] = vals[((int'(bus.fetch_oc) * lh +
                                int'(bus.fetch_y)) * lw +
                               int'(bus.fetch_x)) % 256];
                fetch_idx++;
                hs_count++;
            end
            held_f = bus.fetch_vld && !bus.fetch_ready;
            hx = bus.fetch_x;
            hy = bus.fetch_y;
            hoc = bus.fetch_oc;

            if (held_r) begin
                check("res_hold_vld", bus.res_vld, 1);
                if (bus.res_vld) begin
                    check("res_hold_data", bus.res_data, hd);
                    check("res_hold_last", bus.res_last, hl);
                end
            end

            if (bus.res_vld && bus.res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got 0x%0h expected none",
                             bus.res_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_data", bus.res_data, e.d);
                    check("res_last", bus.res_last, e.l);
                    n_pops++;
                    if (e.l) exp_done_cyc = cyc + 1;
                end
            end
            held_r = bus.res_vld && !bus.res_ready;
            hd = bus.res_data;
            hl = bus.res_last;

            if (done) check("done_cycle", cyc, exp_done_cyc);
        end
    end

    task automatic start_layer(input int w, input int h, input int oc,
                               input logic [3:0] ic, input int frm,
                               input int rrm, input bit preset);
        exp_t e;
        lw = (w > 0) ? w : 1;
        lh = (h > 0) ? h : 1;
        loc = oc;
        lic = ic;
        ltot = w * h * oc;
        for (int i = 0; i < ltot; i++) begin
            if (!preset)
                vals[i] = ($urandom_range(0, 1) != 0) ? $urandom :
                          32'($urandom_range(0, 65535));
            e.d = ref_out(vals[i]);
            e.l = (i == ltot - 1);
            sb.push_back(e);
        end
        fr_mode = frm;
        rr_mode = rrm;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_ofm_w = DIMW'(w);
        cfg_ofm_h = DIMW'(h);
        cfg_oc = DIMW'(oc);
        cfg_ic = ic;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (ltot > 0) begin
            @(negedge clk);
            check("busy_run", busy, 1);
        end
    endtask

    task automatic finish_layer(input int bound);
        bit got;
        got = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got none expected done");
        end
        check("sb_empty", sb.size(), 0);
        check("pops", n_pops, ltot);
        check("fetches", fetch_idx, ltot);
        check("busy_done", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fvld"}, bus.fetch_vld, 0);
        check({tag, "_cvld"}, bus.conv_in_vld, 0);
        check({tag, "_cfg"}, bus.conv_in_ch_cfg, 0);
        check({tag, "_x"}, bus.fetch_x, 0);
        check({tag, "_y"}, bus.fetch_y, 0);
        check({tag, "_oc"}, bus.fetch_oc, 0);
        check({tag, "_rvld"}, bus.res_vld, 0);
        check({tag, "_rdata"}, bus.res_data, 0);
        check({tag, "_rlast"}, bus.res_last, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0;
        start = 1'b0;
        cfg_ofm_w = '0;
        cfg_ofm_h = '0;
        cfg_oc = '0;
        cfg_ic = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        // basic 2x2x1, fetches back to back
        chk_consec = 1;
        start_layer(2, 2, 1, 4'd8, 0, 0, 0);
        finish_layer(200);
        chk_consec = 0;

        // backpressure: consumer stalled for 20 cycles
        start_layer(4, 1, 2, 4'd5, 0, 2, 0);
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("bp_handshakes", hs_count, 4);
        check("bp_fetch_vld", bus.fetch_vld, 0);
        check("bp_busy", busy, 1);
        rr_mode = 0;
        finish_layer(200);

        // fetch_ready pattern 1,0,0,1
        start_layer(3, 1, 1, 4'd3, 2, 0, 0);
        finish_layer(200);

        // zero-size layer
        start_layer(3, 0, 2, 4'd1, 0, 0, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_fvld", bus.fetch_vld, 0);
        repeat (3) begin
            @(negedge clk);
            check("zero_busy_after", busy, 0);
            check("zero_fvld_after", bus.fetch_vld, 0);
        end

        // reset during RUN
        start_layer(4, 4, 4, 4'd7, 1, 1, 0);
        repeat (15) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        start_layer(1, 1, 1, 4'd2, 0, 0, 0);
        finish_layer(200);

        // saturation boundary values
        vals[0] = 32'd70000;
        vals[1] = 32'd1234;
        start_layer(2, 1, 1, 4'd1, 0, 0, 1);
        finish_layer(200);

        // full-rate layer
        chk_consec = 1;
        start_layer(5, 3, 2, 4'd15, 0, 0, 0);
        finish_layer(500);
        chk_consec = 0;

        // random layers with random handshakes
        for (int r = 0; r < 8; r++) begin
            start_layer($urandom_range(1, 4), $urandom_range(1, 4),
                        $urandom_range(1, 4), 4'($urandom_range(0, 15)),
                        1, 1, 0);
            finish_layer(2000);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_sched.md
Name: conv3x3_sched

Overview:
- Sequencer for the 3x3 multi-channel convolution-sum core.
- Walks every output position (x, y) for every output channel and issues one window/weight fetch per position.
- Drives the core's valid and channel-config inputs, tracks results in flight through the core's fixed pipeline, and buffers them in a small FIFO.
- Results leave on a valid/ready stream. The FIFO credit scheme prevents loss, because the core itself cannot stall.

Parameters:
- CORE_LAT, 3, cycles from conv_in_vld to conv_out_vld of the conv core.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
- DIMW, 8, width of the x/y/oc counters and config fields.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_*, begins a layer
- cfg_ofm_w  in  DIMW  output width in positions
- cfg_ofm_h  in  DIMW  output height
- cfg_oc  in  DIMW  number of output channels
- cfg_ic  in  4  active input channels, forwarded to the core
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the layer is complete
- fetch_vld  out  1  request window+weights for fetch_x/fetch_y/fetch_oc
- fetch_ready  in  1  source presents data to the core this cycle
- fetch_x  out  DIMW  output column
- fetch_y  out  DIMW  output row
- fetch_oc  out  DIMW  output channel
- conv_in_vld  out  1  equals fetch_vld & fetch_ready
- conv_in_ch_cfg  out  4  latched cfg_ic
- conv_out_vld  in  1  core result valid
- conv_out_sum  in  32  core result
- res_vld  out  1  FIFO not empty
- res_ready  in  1  consumer accepts
- res_data  out  32  FIFO head
- res_last  out  1  head is the final result of the layer

Behaviour:
- Reset values: all outputs 0. Counters, FIFO and in-flight tracking are cleared. A reset mid-layer aborts the layer silently, with no done pulse.
- FSM states:
  - IDLE: start accepted → RUN. If any of cfg_ofm_w/h/oc is 0, go → DONE instead; no fetches are issued.
  - RUN: issues fetches. After the handshake of the final fetch → DRAIN.
  - DRAIN: waits until in_flight==0 and the FIFO is empty (last result popped) → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- start is ignored unless in IDLE. busy=1 in RUN and DRAIN only.
- Fetch order: x fastest, then y, then oc. Counters advance only on a handshake (fetch_vld & fetch_ready).
  - x wraps at cfg_ofm_w-1 to 0 and increments y.
  - y wraps at cfg_ofm_h-1 to 0 and increments oc.
- fetch_x/y/oc hold their values while fetch_vld=1 and fetch_ready=0.
- In-flight tracking:
  - A CORE_LAT-deep shift register of conv_in_vld drives in_flight (0..CORE_LAT).
  - conv_out_vld is pushed into the FIFO unconditionally.
- Credit rule: fetch_vld=1 only in RUN and only when in_flight + fifo_count < FIFO_DEPTH. This guarantees a push never hits a full FIFO.
  - Simultaneous push and pop keep the count unchanged.
  - An overflow means a protocol violation: assertion in simulation, data dropped in hardware.
- FIFO pop on res_vld & res_ready. res_data and res_last are stable while res_vld=1 and res_ready=0.
- res_last: a results-popped counter compares against total = w*h*oc, computed at 3*DIMW bits. res_last=1 on entry total-1.
- Done timing: done asserts the cycle after the final pop, or 1 cycle after start for zero-size layers.
- Maximum throughput: one fetch per cycle while res_ready is held high, FIFO_DEPTH >= CORE_LAT+1, and fetch_ready=1.

Optional Feature:
- OUT_SAT16_EN defined: res_data = min(conv_out_sum, 65535). Upper 16 bits are 0, and saturation is applied at FIFO push.
- OUT_SAT16_EN undefined: res_data carries the full 32-bit sum unchanged.

Test Plan:
- Basic layer: w=2, h=2, oc=1, cfg_ic=8, fetch_ready=1, res_ready=1.
  - Fetches come out as (0,0,0) (1,0,0) (0,1,0) (1,1,0) on consecutive cycles.
  - Exactly 4 results appear, res_last on the 4th, and done is one cycle after the 4th pop.
- Backpressure: w=4, h=1, oc=2, res_ready=0 for 20 cycles.
  - fetch_vld stops after 4 handshakes, no FIFO overflow, conv_in_ch_cfg=cfg_ic.
  - After release, all 8 results drain in order and res_last is on the 8th.
- Fetch stall: fetch_ready toggles 1,0,0,1 with w=3, h=1, oc=1.
  - fetch_x holds during stalls.
  - conv_in_vld pulses only on handshakes; the sequence is 0,1,2.
- Zero size: start with cfg_ofm_h=0. No fetch_vld, done the cycle after start, busy never 1.
- Reset mid-run: deassert rst_b during RUN of a w=h=oc=4 layer.
  - All outputs return to 0 with no done.
  - A new start with w=h=oc=1 completes normally with 1 result.
- Saturation (OUT_SAT16_EN): core returns 70000 → res_data=65535. Core returns 1234 → 1234. Without the macro, 70000 passes unchanged.
